alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two request ports share one ALU. Every cycle at most one port is granted.
// Its operands are pushed through the ALU, and the result is captured in a
// single-entry result register. A new request can enter in the same cycle
// that the consumer drains the previous result, so the block sustains one
// result per clock.
//
// Ports
//   clk         : clock; all state updates happen on the rising edge
//   rst_n       : synchronous, active-low reset
//   req_valid   : [1:0] per-port request valid (bit i = port i)
//   req_ready   : [1:0] per-port request accepted this cycle
//   req_op      : [1:0] per-port op bit; 1 = register-register form
//   req_funct3  : per-port funct3, port i at [i*F3_LEN +: F3_LEN]
//   req_funct7  : per-port funct7, same packing
//   req_a/req_b : per-port operands, same packing
//   rsp_valid   : result register holds an undelivered result
//   rsp_ready   : consumer takes the result this cycle
//   rsp_out     : registered ALU result
//   rsp_src     : index of the port that issued rsp_out
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N      = 32,
    parameter int F3_LEN = 3,
    parameter int F7_LEN = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_op,
    input  logic [2*F3_LEN-1:0]   req_funct3,
    input  logic [2*F7_LEN-1:0]   req_funct7,
    input  logic [2*N-1:0]        req_a,
    input  logic [2*N-1:0]        req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [N-1:0]          rsp_out,
    output logic                  rsp_src
);

    // funct3 encodings
    localparam logic [F3_LEN-1:0] F3_ADD  = F3_LEN'(0);
    localparam logic [F3_LEN-1:0] F3_SLL  = F3_LEN'(1);
    localparam logic [F3_LEN-1:0] F3_SLT  = F3_LEN'(2);
    localparam logic [F3_LEN-1:0] F3_SLTU = F3_LEN'(3);
    localparam logic [F3_LEN-1:0] F3_XOR  = F3_LEN'(4);
    localparam logic [F3_LEN-1:0] F3_SR   = F3_LEN'(5);
    localparam logic [F3_LEN-1:0] F3_OR   = F3_LEN'(6);
    localparam logic [F3_LEN-1:0] F3_AND  = F3_LEN'(7);

    // funct7 value selecting SUB (with op=1) and the arithmetic right shift
    localparam logic [F7_LEN-1:0] F7_ALT  = F7_LEN'(7'b0100000);
    localparam logic [F7_LEN-1:0] F7_ZERO = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_rsp_out;
    logic               r_rsp_src;
    logic               r_last_grant;

    // per-port unpacked payload
    logic               w_op [2];
    logic [F3_LEN-1:0]  w_f3 [2];
    logic [F7_LEN-1:0]  w_f7 [2];
    logic [N-1:0]       w_a  [2];
    logic [N-1:0]       w_b  [2];

    logic [1:0]         w_grant;
    logic               w_can_accept;
    logic               w_xfer;
    logic               w_sel;

    // payload of the granted port
    logic               w_sel_op;
    logic [F3_LEN-1:0]  w_sel_f3;
    logic [F7_LEN-1:0]  w_sel_f7;
    logic [N-1:0]       w_sel_a;
    logic [N-1:0]       w_sel_b;
    logic [4:0]         w_shamt;
    logic               w_slt;
    logic               w_sltu;
    logic [N-1:0]       w_alu;

    // -------------------------------------------------------------------------
    // Port unpacking and round-robin grant
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic GI_BIT = 1'(gi);

            assign w_op[gi] = req_op[gi];
            assign w_f3[gi] = req_funct3[gi*F3_LEN +: F3_LEN];
            assign w_f7[gi] = req_funct7[gi*F7_LEN +: F7_LEN];
            assign w_a[gi]  = req_a[gi*N +: N];
            assign w_b[gi]  = req_b[gi*N +: N];

            // Port wins when it is alone, or when both request and the
            // other port was served last.
            assign w_grant[gi] = req_valid[gi] &&
                                 (!req_valid[1-gi] || (r_last_grant != GI_BIT));

            // Ready follows the grant only; when the other port is idle a
            // waiting port is still granted, so ready never waits on valid
            // beyond the arbitration rule itself.
            assign req_ready[gi] = w_can_accept && w_grant[gi];
        end
    endgenerate

    // The result slot is free when empty or being drained this cycle. Reset
    // blocks all acceptance so nothing is sampled while rst_n is low.
    assign w_can_accept = rst_n && ((r_state == ST_EMPTY) || rsp_ready);

    // w_grant is one-hot or zero, so any ready bit means a transfer.
    assign w_xfer = |req_ready;
    assign w_sel  = w_grant[1];

    assign w_sel_op = w_op[w_sel];
    assign w_sel_f3 = w_f3[w_sel];
    assign w_sel_f7 = w_f7[w_sel];
    assign w_sel_a  = w_a[w_sel];
    assign w_sel_b  = w_b[w_sel];

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    // Shift amount uses only the low five bits of b; upper bits are ignored.
    assign w_shamt = w_sel_b[4:0];
    assign w_slt   = ($signed(w_sel_a) < $signed(w_sel_b));
    assign w_sltu  = (w_sel_a < w_sel_b);

    always_comb begin
        w_alu = '0;
        case (w_sel_f3)
            F3_ADD: begin
                if (w_sel_op && (w_sel_f7 == F7_ALT)) begin
                    w_alu = w_sel_a - w_sel_b;
                end else begin
                    w_alu = w_sel_a + w_sel_b;
                end
            end
            F3_SLL:  w_alu = w_sel_a << w_shamt;
            F3_SLT:  w_alu = {{(N-1){1'b0}}, w_slt};
            F3_SLTU: w_alu = {{(N-1){1'b0}}, w_sltu};
            F3_XOR:  w_alu = w_sel_a ^ w_sel_b;
            F3_SR: begin
                if (w_sel_f7 == F7_ZERO) begin
                    w_alu = w_sel_a >> w_shamt;
                end else begin
                    w_alu = $signed(w_sel_a) >>> w_shamt;
                end
            end
            F3_OR:   w_alu = w_sel_a | w_sel_b;
            F3_AND:  w_alu = w_sel_a & w_sel_b;
            default: w_alu = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Result register FSM
    //   EMPTY -> FULL  : transfer
    //   FULL  -> FULL  : transfer (with or without drain, back-to-back)
    //   FULL  -> EMPTY : drain with no transfer; result data is left as is
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_rsp_out    <= '0;
            r_rsp_src    <= 1'b0;
            r_last_grant <= 1'b1;     // port 0 wins the first tie
        end else begin
            if (w_xfer) begin
                r_state      <= ST_FULL;
                r_rsp_out    <= w_alu;
                r_rsp_src    <= w_sel;
                r_last_grant <= w_sel;
            end else if ((r_state == ST_FULL) && rsp_ready) begin
                r_state      <= ST_EMPTY;
            end
        end
    end

    // A pending result is being thrown away while rst_n is low, so it is not
    // offered to the consumer in that cycle.
    assign rsp_valid = (r_state == ST_FULL) && rst_n;
    assign rsp_out   = r_rsp_out;
    assign rsp_src   = r_rsp_src;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_funct3;
    logic [13:0] req_funct7;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_src;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_src    (rsp_src)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU
    function automatic logic [31:0] alu_model(input logic op, input logic [2:0] f3,
                                              input logic [6:0] f7,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        r  = 32'h0;
        case (f3)
            3'd0: r = (op && f7 == 7'h20) ? a + ~b + 32'd1 : a + b;
            3'd1: r = a << sh;
            3'd2: r = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
            3'd3: r = {31'h0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
                r = a >> sh;
                if (f7 != 7'h0 && a[31]) r = r | ~(32'hFFFFFFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: expected result pushed at each request transfer, popped
    // and compared when the consumer takes it.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] out;
        logic        src;
    } exp_t;

    exp_t        sb_q[$];
    bit          mon_en = 1'b0;
    logic        m_full = 1'b0;
    logic        m_last = 1'b1;
    logic [31:0] m_last_out = 32'h0;
    logic        m_last_src = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic       g0, g1, can, p;
            logic [1:0] exp_rdy;
            exp_t       e;
            can = rst_n && (!m_full || rsp_ready);
            g0  = req_valid[0] && (!req_valid[1] || m_last == 1'b1);
            g1  = req_valid[1] && (!req_valid[0] || m_last == 1'b0);
            exp_rdy = can ? {g1, g0} : 2'b00;
            chk("mon_req_ready", {62'h0, req_ready}, {62'h0, exp_rdy});
            chk("mon_rsp_valid", {63'h0, rsp_valid}, {63'h0, rst_n && m_full});
            if (rst_n) begin
                if (m_full && sb_q.size() > 0) begin
                    chk("mon_rsp_out", {32'h0, rsp_out}, {32'h0, sb_q[0].out});
                    chk("mon_rsp_src", {63'h0, rsp_src}, {63'h0, sb_q[0].src});
                    if (rsp_ready) begin
                        e = sb_q.pop_front();
                        m_last_out = e.out;
                        m_last_src = e.src;
                        m_full = 1'b0;
                    end
                end else if (!m_full) begin
                    chk("mon_hold_out", {32'h0, rsp_out}, {32'h0, m_last_out});
                    chk("mon_hold_src", {63'h0, rsp_src}, {63'h0, m_last_src});
                end
                if (exp_rdy != 2'b00) begin
                    p = exp_rdy[1];
                    e.out = alu_model(req_op[p], req_funct3[p*3 +: 3], req_funct7[p*7 +: 7],
                                      req_a[p*32 +: 32], req_b[p*32 +: 32]);
                    e.src = p;
                    sb_q.push_back(e);
                    m_last = p;
                    m_full = 1'b1;
                end
            end else begin
                sb_q.delete();
                m_full = 1'b0;
                m_last = 1'b1;
                m_last_out = 32'h0;
                m_last_src = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_port(input logic p, input logic op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        req_op[p]            = op;
        req_funct3[p*3 +: 3] = f3;
        req_funct7[p*7 +: 7] = f7;
        req_a[p*32 +: 32]    = a;
        req_b[p*32 +: 32]    = b;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    // Hold one request until accepted (bounded), return at edge+1.
    task automatic drive_wait(input logic p, output bit ok);
        bit acc;
        ok = 1'b0;
        req_valid    = 2'b00;
        req_valid[p] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = req_ready[p];
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 2'b00;
    endtask

    typedef struct {
        logic        port;
        logic        op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        tbl[0]  = '{1'b0, 1'b1, 3'd0, 7'h00, 32'd5,        32'd7,        32'd12};
        tbl[1]  = '{1'b1, 1'b1, 3'd0, 7'h20, 32'd3,        32'd5,        32'hFFFFFFFE};
        tbl[2]  = '{1'b1, 1'b1, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'hF8000000};
        tbl[3]  = '{1'b1, 1'b1, 3'd5, 7'h00, 32'h80000000, 32'd4,        32'h08000000};
        tbl[4]  = '{1'b0, 1'b1, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1};
        tbl[5]  = '{1'b0, 1'b1, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0};
        tbl[6]  = '{1'b0, 1'b1, 3'd1, 7'h00, 32'd1,        32'h21,       32'd2};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 7'h20, 32'd3,        32'd5,        32'd8};
        tbl[8]  = '{1'b0, 1'b1, 3'd4, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
        tbl[9]  = '{1'b1, 1'b1, 3'd6, 7'h00, 32'h0000F0F0, 32'h00000F00, 32'h0000FFF0};
        tbl[10] = '{1'b0, 1'b1, 3'd7, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        tbl[11] = '{1'b1, 1'b1, 3'd1, 7'h00, 32'd3,        32'hFFFFFFE0, 32'd3};
        tbl[12] = '{1'b0, 1'b1, 3'd5, 7'h00, 32'h80000000, 32'd31,       32'd1};
        tbl[13] = '{1'b1, 1'b1, 3'd2, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0};
        tbl[14] = '{1'b1, 1'b1, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1};
        tbl[15] = '{1'b0, 1'b1, 3'd0, 7'h20, 32'd0,        32'd1,        32'hFFFFFFFF};
        tbl[16] = '{1'b1, 1'b1, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0};

        req_op = 2'b00; req_funct3 = '0; req_funct7 = '0; req_a = '0; req_b = '0;
        do_reset();
        chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset_rsp_out",   {32'h0, rsp_out},   64'h0);
        chk("reset_rsp_src",   {63'h0, rsp_src},   64'h0);
        chk("reset_req_ready", {62'h0, req_ready}, 64'h0);

        // Table-driven ALU vectors, one per request
        rsp_ready = 1'b1;
        foreach (tbl[i]) begin
            set_port(tbl[i].port, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b);
            drive_wait(tbl[i].port, ok);
            chk($sformatf("vec%0d_accept", i), {63'h0, ok}, 64'h1);
            chk($sformatf("vec%0d_valid", i), {63'h0, rsp_valid}, 64'h1);
            chk($sformatf("vec%0d_out", i), {32'h0, rsp_out}, {32'h0, tbl[i].exp});
            chk($sformatf("vec%0d_src", i), {63'h0, rsp_src}, {63'h0, tbl[i].port});
            $display("[TB] vec %0d port %0d f3 %0d a 0x%08h b 0x%08h -> 0x%08h",
                     i, tbl[i].port, tbl[i].f3, tbl[i].a, tbl[i].b, rsp_out);
        end
        repeat (2) @(posedge clk);
        #1;

        // Both ports valid every cycle: alternate 0,1,0,1 from reset
        do_reset();
        set_port(1'b0, 1'b1, 3'd0, 7'h00, 32'd1,  32'd1);   // 2
        set_port(1'b1, 1'b1, 3'd0, 7'h20, 32'd10, 32'd3);   // 7
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("alt%0d_valid", i), {63'h0, rsp_valid}, 64'h1);
            chk($sformatf("alt%0d_src", i), {63'h0, rsp_src}, (i % 2));
            chk($sformatf("alt%0d_out", i), {32'h0, rsp_out}, (i % 2) ? 64'd7 : 64'd2);
            $display("[TB] alt cycle %0d src %0d out %0d", i, rsp_src, rsp_out);
        end

        // Stall while FULL with both ports valid, then release
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_ready", i), {62'h0, req_ready}, 64'h0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", i), {63'h0, rsp_valid}, 64'h1);
            chk($sformatf("stall%0d_out", i), {32'h0, rsp_out}, 64'd2);
            chk($sformatf("stall%0d_src", i), {63'h0, rsp_src}, 64'h0);
            $display("[TB] stall cycle %0d out %0d", i, rsp_out);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", {62'h0, req_ready}, 64'h2);
        @(posedge clk);
        #1;
        chk("release_valid", {63'h0, rsp_valid}, 64'h1);
        chk("release_out",   {32'h0, rsp_out},   64'd7);
        chk("release_src",   {63'h0, rsp_src},   64'h1);
        $display("[TB] release out %0d src %0d", rsp_out, rsp_src);

        // Reset while FULL with rsp_ready low discards the result
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstfull_ready_low", {62'h0, req_ready}, 64'h0);
        @(posedge clk);
        #1;
        chk("rstfull_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rstfull_out",   {32'h0, rsp_out},   64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstfull_first_tie", {62'h0, req_ready}, 64'h1);
        @(posedge clk);
        #1;
        chk("rstfull_tie_src", {63'h0, rsp_src}, 64'h0);
        chk("rstfull_tie_out", {32'h0, rsp_out}, 64'd2);
        $display("[TB] reset-while-full: tie src %0d out %0d", rsp_src, rsp_out);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", {32'h0, 32'(sb_q.size())}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
